// File: rtl/hbm_rd_arbiter_pkg.sv
// Shared FSM state type and AXI constants for the HBM read arbiter.
package hbm_rd_arbiter_pkg;

  typedef enum logic {
    ARB   = 1'b0,
    ISSUE = 1'b1
  } arb_state_t;

  localparam logic [2:0] HBM_AXI_SIZE       = 3'b101;
  localparam logic [1:0] HBM_AXI_BURST_INCR = 2'b01;
  localparam int         HBM_DATA_BITS      = 256;
  localparam int         HBM_ADDR_BITS      = 64;
  localparam int         HBM_LEN_BITS       = 8;

  // Beats are 32 bytes wide, so the low five address bits never reach AR.
  localparam logic [HBM_ADDR_BITS-1:0] HBM_BEAT_MASK = ~64'h1F;

endpackage

// File: rtl/hbm_rd_arbiter_if.sv
// Requester, AXI read and read-return signals of the HBM read arbiter.
// master = the arbiter itself, slave = requesters plus the memory side.
interface hbm_rd_arbiter_if #(
  parameter int N_REQ = 4
);
  import hbm_rd_arbiter_pkg::*;

  logic [N_REQ-1:0]              req_valid;
  logic [N_REQ-1:0]              req_ready;
  logic [N_REQ*HBM_ADDR_BITS-1:0] req_addr;
  logic [N_REQ*HBM_LEN_BITS-1:0]  req_len;

  logic [HBM_ADDR_BITS-1:0] m_axi_araddr;
  logic [HBM_LEN_BITS-1:0]  m_axi_arlen;
  logic [2:0]               m_axi_arsize;
  logic [1:0]               m_axi_arburst;
  logic                     m_axi_arvalid;
  logic                     m_axi_arready;

  logic [HBM_DATA_BITS-1:0] m_axi_rdata;
  logic [1:0]               m_axi_rresp;
  logic                     m_axi_rlast;
  logic                     m_axi_rvalid;
  logic                     m_axi_rready;

  logic [HBM_DATA_BITS-1:0] rd_data;
  logic [1:0]               rd_resp;
  logic                     rd_last;
  logic [N_REQ-1:0]         rd_valid;
  logic [N_REQ-1:0]         rd_ready;

  modport master (
    input  req_valid, req_addr, req_len,
    output req_ready,
    output m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst, m_axi_arvalid,
    input  m_axi_arready,
    input  m_axi_rdata, m_axi_rresp, m_axi_rlast, m_axi_rvalid,
    output m_axi_rready,
    output rd_data, rd_resp, rd_last, rd_valid,
    input  rd_ready
  );

  modport slave (
    output req_valid, req_addr, req_len,
    input  req_ready,
    input  m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst, m_axi_arvalid,
    output m_axi_arready,
    output m_axi_rdata, m_axi_rresp, m_axi_rlast, m_axi_rvalid,
    input  m_axi_rready,
    input  rd_data, rd_resp, rd_last, rd_valid,
    output rd_ready
  );

endinterface

// File: rtl/hbm_rd_route_fifo.sv
// In-order FIFO of requester ids for bursts in flight; head id steers R beats.
module hbm_rd_route_fifo #(
  parameter int WIDTH = 2,
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  output logic [WIDTH-1:0]       head,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W-1:0] PTR_ONE = 1;
  localparam logic [PTR_W:0]   CNT_ONE = 1;
  localparam logic [PTR_W:0]   CNT_MAX = DEPTH;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CNT_MAX);
  assign do_pop  = pop & ~empty;
  // A pop frees the slot in the same cycle, so push is legal even when full.
  assign do_push = push & (~full | do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/hbm_rd_arbiter.sv
// Round-robin AR arbiter for N_REQ read requesters with in-order R routing by burst.
// Define HBM_RD_ARB_STATS_EN to add the stat_grants / stat_stall counters.
module hbm_rd_arbiter
  import hbm_rd_arbiter_pkg::*;
#(
  parameter int N_REQ           = 4,
  parameter int MAX_OUTSTANDING = 16
) (
  input  logic aclk,
  input  logic areset,
  hbm_rd_arbiter_if.master bus
`ifdef HBM_RD_ARB_STATS_EN
  ,
  output logic [N_REQ*32-1:0] stat_grants,
  output logic [31:0]         stat_stall
`endif
);

  // state | meaning
  // ARB   | search for a requester; grant only while a routing slot is free
  // ISSUE | AR registers loaded, arvalid held until arready

  localparam int ID_W  = $clog2(N_REQ);
  localparam int CNT_W = $clog2(MAX_OUTSTANDING) + 1;
  localparam logic [CNT_W-1:0] CNT_LIMIT = MAX_OUTSTANDING;

  arb_state_t               state;
  logic [ID_W-1:0]          rr_ptr;
  logic [ID_W-1:0]          ar_id;
  logic [HBM_ADDR_BITS-1:0] ar_addr;
  logic [HBM_LEN_BITS-1:0]  ar_len;
  logic                     ar_valid;

  logic [ID_W-1:0]          cand;
  logic [ID_W-1:0]          grant_id;
  logic                     grant_found;
  logic                     grant_ok;
  logic [HBM_ADDR_BITS-1:0] sel_addr;
  logic [HBM_LEN_BITS-1:0]  sel_len;

  logic                     push;
  logic                     pop;
  logic [ID_W-1:0]          head_id;
  logic                     fifo_full;
  logic                     fifo_empty;
  logic [CNT_W-1:0]         occupancy;

  always_comb begin
    grant_found = 1'b0;
    grant_id    = '0;
    cand        = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      cand = ID_W'((int'(rr_ptr) + k) % N_REQ);
      if (!grant_found && bus.req_valid[cand]) begin
        grant_found = 1'b1;
        grant_id    = cand;
      end
    end
  end

  assign grant_ok = (state == ARB) && grant_found && !fifo_full;
  assign sel_addr = bus.req_addr[int'(grant_id)*HBM_ADDR_BITS +: HBM_ADDR_BITS];
  assign sel_len  = bus.req_len[int'(grant_id)*HBM_LEN_BITS +: HBM_LEN_BITS];

  // Gated by reset so a requester holding valid sees no ready while in reset.
  always_comb begin
    bus.req_ready = '0;
    if (grant_ok && !areset) bus.req_ready[grant_id] = 1'b1;
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state    <= ARB;
      rr_ptr   <= ID_W'(N_REQ - 1);
      ar_id    <= '0;
      ar_addr  <= '0;
      ar_len   <= '0;
      ar_valid <= 1'b0;
    end else begin
      case (state)
        ARB: begin
          if (grant_ok) begin
            rr_ptr   <= grant_id;
            ar_id    <= grant_id;
            ar_addr  <= sel_addr & HBM_BEAT_MASK;
            ar_len   <= sel_len;
            ar_valid <= 1'b1;
            state    <= ISSUE;
          end
        end
        ISSUE: begin
          if (bus.m_axi_arready) begin
            ar_valid <= 1'b0;
            state    <= ARB;
          end
        end
        default: state <= ARB;
      endcase
    end
  end

  assign bus.m_axi_araddr  = ar_addr;
  assign bus.m_axi_arlen   = ar_len;
  assign bus.m_axi_arsize  = HBM_AXI_SIZE;
  assign bus.m_axi_arburst = HBM_AXI_BURST_INCR;
  assign bus.m_axi_arvalid = ar_valid;

  assign push = ar_valid & bus.m_axi_arready;
  assign pop  = bus.m_axi_rvalid & bus.m_axi_rready & bus.m_axi_rlast;

  hbm_rd_route_fifo #(
    .WIDTH (ID_W),
    .DEPTH (MAX_OUTSTANDING)
  ) u_fifo (
    .clk       (aclk),
    .rst       (areset),
    .push      (push),
    .push_data (ar_id),
    .pop       (pop),
    .head      (head_id),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (occupancy)
  );

  a_occupancy_bound: assert property (@(posedge aclk) disable iff (areset)
    occupancy <= CNT_LIMIT);

  // Beats arriving with nothing in flight are left stalled on the bus.
  always_comb begin
    bus.rd_valid = '0;
    if (!fifo_empty) bus.rd_valid[head_id] = bus.m_axi_rvalid;
  end

  assign bus.m_axi_rready = !fifo_empty & bus.rd_ready[head_id];
  assign bus.rd_data      = bus.m_axi_rdata;
  assign bus.rd_resp      = bus.m_axi_rresp;
  assign bus.rd_last      = bus.m_axi_rlast;

`ifdef HBM_RD_ARB_STATS_EN
  logic [31:0] grant_cnt [N_REQ];

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      for (int i = 0; i < N_REQ; i++) grant_cnt[i] <= '0;
      stat_stall <= '0;
    end else begin
      if (push && grant_cnt[ar_id] != '1) grant_cnt[ar_id] <= grant_cnt[ar_id] + 32'd1;
      if (state == ARB && fifo_full && |bus.req_valid && stat_stall != '1)
        stat_stall <= stat_stall + 32'd1;
    end
  end

  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_stat
    assign stat_grants[gi*32 +: 32] = grant_cnt[gi];
  end
`endif

endmodule
